// File: rtl/tiny_alu_mc.sv
// tiny_alu_mc: small ALU with a start/busy/done handshake.
// Single-cycle logic/add/sub operations issue back-to-back. MUL runs as a
// shift-add sequence over DATA_WIDTH clocks, during which busy_o is high and
// new requests are ignored. All outputs come straight from registers.
module tiny_alu_mc #(
    parameter int DATA_WIDTH  = 8,
    parameter int OPCODE_BITS = 3
) (
    input  logic                      clk_i,
    input  logic                      reset_n_i,
    input  logic [DATA_WIDTH-1:0]     a_i,
    input  logic [DATA_WIDTH-1:0]     b_i,
    input  logic [OPCODE_BITS-1:0]    opcode_i,
    input  logic                      start_i,
    output logic                      busy_o,
    output logic [2*DATA_WIDTH-1:0]   result_o,
    output logic                      done_o,
    output logic                      err_o
);

    localparam int RW = 2 * DATA_WIDTH;
    localparam int CW = (DATA_WIDTH > 2) ? $clog2(DATA_WIDTH) : 1;

    localparam logic [2:0] OP_NOP = 3'd0;
    localparam logic [2:0] OP_ADD = 3'd1;
    localparam logic [2:0] OP_AND = 3'd2;
    localparam logic [2:0] OP_XOR = 3'd3;
    localparam logic [2:0] OP_MUL = 3'd4;
    localparam logic [2:0] OP_OR  = 3'd5;
    localparam logic [2:0] OP_SUB = 3'd6;

    typedef enum logic [0:0] {
        ST_IDLE = 1'b0,
        ST_MUL  = 1'b1
    } state_e;

    state_e          state_q, state_d;
    logic [RW-1:0]   mcand_q, mcand_d;    // multiplicand, shifted left once per iteration
    logic [DATA_WIDTH-1:0] mplier_q, mplier_d; // multiplier, shifted right once per iteration
    logic [RW-1:0]   acc_q, acc_d;
    logic [CW-1:0]   cnt_q, cnt_d;        // iterations left after the current one
    logic [RW-1:0]   result_q, result_d;
    logic            done_q, done_d;
    logic            err_q, err_d;

    logic [RW-1:0]   a_ext_s;
    logic [RW-1:0]   b_ext_s;
    logic            invalid_s;

    // Partial product for one shift-add step: the shifted multiplicand when
    // the current multiplier bit is set, otherwise zero.
    function automatic logic [RW-1:0] partial_product(
        input logic [RW-1:0] mcand,
        input logic          bit_set
    );
        logic [RW-1:0] pp;
        if (bit_set) begin
            pp = mcand;
        end else begin
            pp = '0;
        end
        return pp;
    endfunction

    assign a_ext_s   = {{DATA_WIDTH{1'b0}}, a_i};
    assign b_ext_s   = {{DATA_WIDTH{1'b0}}, b_i};
    // Anything above 6 is invalid: opcode 7, or any nonzero bit above [2:0].
    assign invalid_s = (opcode_i > OPCODE_BITS'(6));

    // Next-state, datapath and completion logic for IDLE and MUL.
    always_comb begin
        state_d  = state_q;
        mcand_d  = mcand_q;
        mplier_d = mplier_q;
        acc_d    = acc_q;
        cnt_d    = cnt_q;
        result_d = result_q;
        err_d    = err_q;
        done_d   = 1'b0;

        case (state_q)
            ST_IDLE: begin
                if (start_i) begin
                    if (invalid_s) begin
                        result_d = '0;
                        err_d    = 1'b1;
                        done_d   = 1'b1;
                    end else begin
                        case (opcode_i[2:0])
                            OP_NOP: begin
                                err_d  = 1'b0;
                                done_d = 1'b1;
                            end
                            OP_ADD: begin
                                result_d = a_ext_s + b_ext_s;
                                err_d    = 1'b0;
                                done_d   = 1'b1;
                            end
                            OP_AND: begin
                                result_d = a_ext_s & b_ext_s;
                                err_d    = 1'b0;
                                done_d   = 1'b1;
                            end
                            OP_XOR: begin
                                result_d = a_ext_s ^ b_ext_s;
                                err_d    = 1'b0;
                                done_d   = 1'b1;
                            end
                            OP_OR: begin
                                result_d = a_ext_s | b_ext_s;
                                err_d    = 1'b0;
                                done_d   = 1'b1;
                            end
                            OP_SUB: begin
                                // 2W-bit wraparound gives the sign-extended difference.
                                result_d = a_ext_s - b_ext_s;
                                err_d    = 1'b0;
                                done_d   = 1'b1;
                            end
                            OP_MUL: begin
                                // The accepting edge already folds in multiplier bit 0,
                                // so DATA_WIDTH-1 more edges finish the product.
                                acc_d    = partial_product(a_ext_s, b_i[0]);
                                mcand_d  = a_ext_s << 1;
                                mplier_d = b_i >> 1;
                                cnt_d    = CW'(DATA_WIDTH - 2);
                                state_d  = ST_MUL;
                            end
                            default: begin
                                result_d = '0;
                                err_d    = 1'b1;
                                done_d   = 1'b1;
                            end
                        endcase
                    end
                end else begin
                    done_d = 1'b0;
                end
            end
            ST_MUL: begin
                if (cnt_q == '0) begin
                    result_d = acc_q + partial_product(mcand_q, mplier_q[0]);
                    err_d    = 1'b0;
                    done_d   = 1'b1;
                    state_d  = ST_IDLE;
                end else begin
                    acc_d    = acc_q + partial_product(mcand_q, mplier_q[0]);
                    mcand_d  = mcand_q << 1;
                    mplier_d = mplier_q >> 1;
                    cnt_d    = cnt_q - CW'(1);
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // State and datapath registers; reset clears everything, aborting any MUL.
    always_ff @(posedge clk_i or negedge reset_n_i) begin
        if (!reset_n_i) begin
            state_q  <= ST_IDLE;
            mcand_q  <= '0;
            mplier_q <= '0;
            acc_q    <= '0;
            cnt_q    <= '0;
            result_q <= '0;
            done_q   <= 1'b0;
            err_q    <= 1'b0;
        end else begin
            state_q  <= state_d;
            mcand_q  <= mcand_d;
            mplier_q <= mplier_d;
            acc_q    <= acc_d;
            cnt_q    <= cnt_d;
            result_q <= result_d;
            done_q   <= done_d;
            err_q    <= err_d;
        end
    end

    assign busy_o   = (state_q == ST_MUL);
    assign result_o = result_q;
    assign done_o   = done_q;
    assign err_o    = err_q;

endmodule
